// File: rtl/rstack_ctrl.sv
// rstack_ctrl: return-stack controller for the brus16 core.
// Turns call/return push/pop requests into write and read addresses for
// an external return-stack memory (synchronous write, asynchronous read).
// It also tracks depth and exposes the top of stack. Overflow and underflow
// are trapped in a sticky ERROR state until clear is asserted.
module rstack_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] top,
    output logic [WIDTH:0]        depth,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  unf,
    output logic                  err,
    output logic [WIDTH-1:0]      mem_dout_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  we,
    output logic [WIDTH-1:0]      mem_din_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    localparam logic [WIDTH:0]   DEPTH_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   DEPTH_FULL = (WIDTH+1)'(SIZE);
    localparam logic [WIDTH:0]   DEPTH_ZERO = '0;
    localparam logic [WIDTH-1:0] SP_ONE     = WIDTH'(1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH:0]   depth_q;
    logic [WIDTH:0]   depth_n;
    logic             ovf_q;
    logic             ovf_n;
    logic             unf_q;
    logic             unf_n;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] sp_m1;
    logic             is_empty;
    logic             is_full;

    // The stack pointer is the low bits of depth. When the stack is full it
    // reads 0, and depth keeps the extra bit that tells full apart from empty.
    assign sp       = depth_q[WIDTH-1:0];
    assign sp_m1    = sp - SP_ONE;
    assign is_empty = (depth_q == DEPTH_ZERO);
    assign is_full  = (depth_q == DEPTH_FULL);

    assign depth         = depth_q;
    assign empty         = is_empty;
    assign full          = is_full;
    assign ovf           = ovf_q;
    assign unf           = unf_q;
    assign err           = (state == ST_ERROR);
    assign mem_dout_addr = sp_m1;
    assign mem_din       = push_data;
    assign top           = is_empty ? '0 : mem_dout;

    // State register: reset and clear both return to an empty RUN stack with flags cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            depth_q <= depth_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
        end
    end

    // Next-state and memory-write decode; clear outranks requests, and reset masks any write.
    always_comb begin
        state_n      = state;
        depth_n      = depth_q;
        ovf_n        = ovf_q;
        unf_n        = unf_q;
        we           = 1'b0;
        mem_din_addr = sp;

        if (clear) begin
            state_n = ST_RUN;
            depth_n = '0;
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
        end else if (state == ST_RUN) begin
            unique case ({push, pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_n   = 1'b1;
                        state_n = ST_ERROR;
                    end else begin
                        we      = 1'b1;
                        depth_n = depth_q + DEPTH_ONE;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_n   = 1'b1;
                        state_n = ST_ERROR;
                    end else begin
                        depth_n = depth_q - DEPTH_ONE;
                    end
                end
                2'b11: begin
                    if (is_empty) begin
                        unf_n   = 1'b1;
                        state_n = ST_ERROR;
                    end else begin
                        we           = 1'b1;
                        mem_din_addr = sp_m1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (rst) begin
            we = 1'b0;
        end
    end

endmodule

// File: tb/tb_rstack_ctrl.sv
// tb_rstack_ctrl: testbench for rstack_ctrl with an attached return-stack
// memory. Expected outputs come from a queue-based stack model. Fixed
// vectors and corner-case sequences are also checked against constants.
module tb_rstack_ctrl;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic [12:0] push_data;
    logic        clear;
    logic [12:0] top;
    logic [4:0]  depth;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        err;
    logic [3:0]  mem_dout_addr;
    logic [12:0] mem_dout;
    logic        we;
    logic [3:0]  mem_din_addr;
    logic [12:0] mem_din;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stack as a queue plus the sticky flags.
    int q[$];
    bit m_ovf;
    bit m_unf;
    bit m_err;

    logic [12:0] mem [16];

    rstack_ctrl #(.WIDTH(4), .SIZE(16), .DATA_WIDTH(13)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
        .clear(clear), .top(top), .depth(depth), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf), .err(err), .mem_dout_addr(mem_dout_addr),
        .mem_dout(mem_dout), .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return-stack memory: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (we) mem[mem_din_addr] <= mem_din;
    end
    assign mem_dout = mem[mem_dout_addr];

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model for the current inputs.
    task automatic checkOutput();
        int sz;
        bit exp_we;
        sz = q.size();
        exp_we = !rst && !clear && !m_err &&
                 ((push && !pop && sz < 16) || (push && pop && sz > 0));
        cmp("depth", int'(depth), sz);
        cmp("empty", int'(empty), int'(sz == 0));
        cmp("full", int'(full), int'(sz == 16));
        cmp("ovf", int'(ovf), int'(m_ovf));
        cmp("unf", int'(unf), int'(m_unf));
        cmp("err", int'(err), int'(m_err));
        cmp("top", int'(top), (sz == 0) ? 0 : q[sz-1]);
        cmp("mem_dout_addr", int'(mem_dout_addr), (sz - 1) & 15);
        cmp("we", int'(we), int'(exp_we));
        if (exp_we) cmp("mem_din_addr", int'(mem_din_addr), (push && pop) ? (sz - 1) & 15 : sz & 15);
        cmp("mem_din", int'(mem_din), int'(push_data));
    endtask

    task automatic updateModel();
        int sz;
        sz = q.size();
        if (rst || clear) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_err = 0;
        end else if (!m_err) begin
            if (push && !pop) begin
                if (sz == 16) begin m_ovf = 1; m_err = 1; end
                else q.push_back(int'(push_data));
            end else if (pop && !push) begin
                if (sz == 0) begin m_unf = 1; m_err = 1; end
                else void'(q.pop_back());
            end else if (push && pop) begin
                if (sz == 0) begin m_unf = 1; m_err = 1; end
                else q[sz-1] = int'(push_data);
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the model outputs.
    task automatic applyStimulus(input logic r, input logic c, input logic pu,
                                 input logic po, input logic [12:0] d);
        @(negedge clk);
        rst = r;
        clear = c;
        push = pu;
        pop = po;
        push_data = d;
        #1;
        checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        updateModel();
    endtask

    task automatic step(input logic r, input logic c, input logic pu,
                        input logic po, input logic [12:0] d);
        applyStimulus(r, c, pu, po, d);
        clockEdge();
    endtask

    typedef struct {
        logic        rst, clear, push, pop;
        logic [12:0] data;
        logic        exp_we;
        int          exp_depth;
        logic [12:0] exp_top;
        logic        exp_err;
        int          exp_addr;
    } vec_t;

    vec_t tbl[20];

    initial begin
        foreach (mem[i]) mem[i] = '0;
        m_ovf = 0; m_unf = 0; m_err = 0;
        rst = 1; clear = 0; push = 0; pop = 0; push_data = '0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 0, 13'h0);

        tbl[0]  = '{0, 0, 1, 0, 13'h100, 1, 0, 13'h000, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 13'h101, 1, 1, 13'h100, 0, 1};
        tbl[2]  = '{0, 0, 1, 0, 13'h102, 1, 2, 13'h101, 0, 2};
        tbl[3]  = '{0, 0, 0, 1, 13'h000, 0, 3, 13'h102, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 13'h000, 0, 2, 13'h101, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 13'h000, 0, 1, 13'h100, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 13'h000, 0, 0, 13'h000, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 13'h000, 0, 0, 13'h000, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 13'h1FFF, 0, 0, 13'h000, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 13'h000, 0, 0, 13'h000, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 13'h010, 1, 0, 13'h000, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 13'h020, 1, 1, 13'h010, 0, 1};
        tbl[12] = '{0, 0, 1, 1, 13'h055, 1, 2, 13'h020, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 13'h000, 0, 2, 13'h055, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 13'h000, 0, 2, 13'h055, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 13'h000, 0, 1, 13'h010, 0, 0};
        tbl[16] = '{0, 0, 1, 1, 13'h077, 0, 0, 13'h000, 0, 0};
        tbl[17] = '{0, 0, 0, 0, 13'h000, 0, 0, 13'h000, 1, 0};
        tbl[18] = '{0, 1, 0, 0, 13'h000, 0, 0, 13'h000, 1, 0};
        tbl[19] = '{0, 0, 0, 0, 13'h000, 0, 0, 13'h000, 0, 0};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].clear, tbl[i].push, tbl[i].pop, tbl[i].data);
            cmp($sformatf("tbl%0d.we", i), int'(we), int'(tbl[i].exp_we));
            cmp($sformatf("tbl%0d.depth", i), int'(depth), tbl[i].exp_depth);
            cmp($sformatf("tbl%0d.top", i), int'(top), int'(tbl[i].exp_top));
            cmp($sformatf("tbl%0d.err", i), int'(err), int'(tbl[i].exp_err));
            if (tbl[i].exp_we) cmp($sformatf("tbl%0d.addr", i), int'(mem_din_addr), tbl[i].exp_addr);
            clockEdge();
        end

        $display("[TB] overflow sequence");
        step(1, 0, 0, 0, 13'h0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 13'(i));
        applyStimulus(0, 0, 1, 0, 13'h1AB);
        cmp("ovf17.full", int'(full), 1);
        cmp("ovf17.depth", int'(depth), 16);
        cmp("ovf17.we", int'(we), 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 13'h0);
        cmp("ovf.flag", int'(ovf), 1);
        cmp("ovf.err", int'(err), 1);
        cmp("ovf.depth", int'(depth), 16);
        cmp("ovf.top", int'(top), 13'h00F);
        clockEdge();

        $display("[TB] clear with push");
        step(0, 1, 0, 0, 13'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 13'(13'h200 + i));
        applyStimulus(0, 1, 1, 0, 13'h333);
        cmp("clr.depth_before", int'(depth), 5);
        cmp("clr.we", int'(we), 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 13'h0);
        cmp("clr.depth", int'(depth), 0);
        cmp("clr.err", int'(err), 0);
        clockEdge();

        $display("[TB] reset with push");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 13'(13'h300 + i));
        applyStimulus(1, 0, 1, 0, 13'hAAA);
        cmp("rst.we", int'(we), 0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 13'h0);
        cmp("rst.depth", int'(depth), 0);
        cmp("rst.top", int'(top), 0);
        clockEdge();

        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            logic r, c, pu, po;
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 40);
            step(r, c, pu, po, 13'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
